seg7_time_scanner: RTL and testbench

Downstream display stage for the clock block. Takes the formatted time fields (`display_hour`, `display_min`, `display_sec`, `is_pm`, `hour_format`) and drives a 6-digit multiplexed common-anode 7-segment display. It converts each field to two BCD digits, snapshots the fields once per scan frame to prevent tearing, and inserts an inter-digit guard cycle against ghosting. It blinks the field currently being edited.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_time_scanner_bcd.sv | 16 +
 rtl/seg7_time_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_time_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 6-digit time scanner.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_SEC  = 2'b01;
  localparam logic [1:0] BLINK_MIN  = 2'b10;
  localparam logic [1:0] BLINK_HOUR = 2'b11;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_time_scanner_bcd.sv
// bin2bcd_2digit: binary 0..255 to two BCD digits.
// Ports: bin in; tens/ones out; overflow set when bin >= 100.
module bin2bcd_2digit (
  input  logic [7:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       overflow
);

  always_comb begin
    overflow = (bin >= 8'd100);
    tens     = 4'(bin / 8'd10);
    ones     = 4'(bin % 8'd10);
  end

endmodule

// File: rtl/seg7_time_scanner.sv
// seg7_time_scanner: 6-digit multiplexed common-anode time display.
// In: clk, reset, hour/min/sec, is_pm, hour_format, blink_sel. Out: seg_n, dp_n, an_n.
module seg7_time_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] display_hour,
  input  logic [7:0] display_min,
  input  logic [7:0] display_sec,
  input  logic       is_pm,
  input  logic       hour_format,
  input  logic [1:0] blink_sel,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          primed;

  logic [7:0] snap_hour;
  logic [7:0] snap_min;
  logic [7:0] snap_sec;
  logic       snap_pm;
  logic       snap_fmt;

  logic scan_wrap;
  logic load;

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign load = (scan_wrap && digit_idx == DIG_HOUR_TENS)
              || !primed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= DIG_SEC_ONES;
    end else if (scan_wrap) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_HOUR_TENS)
                 ? DIG_SEC_ONES
                 : digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // One coherent snapshot per frame keeps digits from tearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
      snap_pm   <= 1'b0;
      snap_fmt  <= 1'b0;
      primed    <= 1'b0;
    end else if (load) begin
      snap_hour <= display_hour;
      snap_min  <= display_min;
      snap_sec  <= display_sec;
      snap_pm   <= is_pm;
      snap_fmt  <= hour_format;
      primed    <= 1'b1;
    end
  end

  logic [3:0] h_tens, h_ones;
  logic [3:0] m_tens, m_ones;
  logic [3:0] s_tens, s_ones;
  logic       h_ovf, m_ovf, s_ovf;

  bin2bcd_2digit u_hour (
    .bin      (snap_hour),
    .tens     (h_tens),
    .ones     (h_ones),
    .overflow (h_ovf)
  );

  bin2bcd_2digit u_min (
    .bin      (snap_min),
    .tens     (m_tens),
    .ones     (m_ones),
    .overflow (m_ovf)
  );

  bin2bcd_2digit u_sec (
    .bin      (snap_sec),
    .tens     (s_tens),
    .ones     (s_ones),
    .overflow (s_ovf)
  );

  logic [3:0] nib;
  logic       ovf;
  logic [1:0] field;
  logic       dp_on;
  logic       lead_blank;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [5:0] an_d;

  always_comb begin
    nib        = 4'd0;
    ovf        = 1'b0;
    field      = BLINK_NONE;
    dp_on      = 1'b0;
    lead_blank = 1'b0;
    unique case (digit_idx)
      DIG_SEC_ONES: begin
        nib   = s_ones;
        ovf   = s_ovf;
        field = BLINK_SEC;
        dp_on = snap_fmt & snap_pm;
      end
      DIG_SEC_TENS: begin
        nib   = s_tens;
        ovf   = s_ovf;
        field = BLINK_SEC;
      end
      DIG_MIN_ONES: begin
        nib   = m_ones;
        ovf   = m_ovf;
        field = BLINK_MIN;
        dp_on = 1'b1;
      end
      DIG_MIN_TENS: begin
        nib   = m_tens;
        ovf   = m_ovf;
        field = BLINK_MIN;
      end
      DIG_HOUR_ONES: begin
        nib   = h_ones;
        ovf   = h_ovf;
        field = BLINK_HOUR;
        dp_on = 1'b1;
      end
      DIG_HOUR_TENS: begin
        nib        = h_tens;
        ovf        = h_ovf;
        field      = BLINK_HOUR;
        lead_blank = snap_fmt && (h_tens == 4'd0);
      end
      default: ;
    endcase

    seg_d = ovf ? SEG_DASH : seg_encode(nib);
    if (!ovf && lead_blank) seg_d = SEG_BLANK;
    dp_d = ~dp_on;

    if (blink_phase && blink_sel != BLINK_NONE
        && blink_sel == field) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end

    an_d = ~(6'b000001 << digit_idx);

    // First cycle of each slot is dead time against ghosting.
    if (scan_cnt == '0) begin
      an_d  = 6'h3F;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= 6'h3F;
    end else begin
      seg_n <= seg_d;
      dp_n  <= dp_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_time_scanner.sv
// tb_seg7_time_scanner: directed scoreboard bench for the scanner.
// Expected digit tables are written out per scenario as constants.
module tb_seg7_time_scanner;

  localparam int SCAN  = 4;
  localparam int BLINK = 64;
  localparam int FRAME = 6 * SCAN;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] display_hour;
  logic [7:0] display_min;
  logic [7:0] display_sec;
  logic       is_pm;
  logic       hour_format;
  logic [1:0] blink_sel;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  seg7_time_scanner #(
    .SCAN_DIV  (SCAN),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .display_hour (display_hour),
    .display_min  (display_min),
    .display_sec  (display_sec),
    .is_pm        (is_pm),
    .hour_format  (hour_format),
    .blink_sel    (blink_sel),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .an_n         (an_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       active;
  } exp_t;

  exp_t  sb[$];
  int    k;
  int    n_assert = 0;
  int    n_fail = 0;
  int    new_from;
  string tag;

  logic [6:0] tbl_seg [2][6];
  logic       tbl_dp  [2][6];

  // Clock edges since reset release.
  always @(posedge clk or posedge reset)
    if (reset) k <= 0;
    else k <= k + 1;

  function automatic exp_t model(input int kk);
    exp_t       e;
    int         s, d, f, t;
    logic       blk;
    logic [5:0] oh;
    s   = (kk - 1) % SCAN;
    d   = ((kk - 1) / SCAN) % 6;
    f   = (kk - 1) / FRAME;
    t   = (f >= new_from) ? 1 : 0;
    blk = (blink_sel != 2'b00)
       && (int'(blink_sel) == d / 2 + 1)
       && ((((kk - 1) / BLINK) % 2) == 1);
    oh  = 6'd1 << d;
    e.active = (s != 0);
    e.an     = e.active ? ~oh : 6'h3F;
    e.seg    = blk ? 7'h7F : tbl_seg[t][d];
    e.dp     = blk ? 1'b1 : tbl_dp[t][d];
    return e;
  endfunction

  task automatic load_tbl(input int i,
                          input logic [41:0] segs,
                          input logic [5:0] dps);
    for (int d = 0; d < 6; d++) begin
      tbl_seg[i][d] = segs[7*d +: 7];
      tbl_dp[i][d]  = dps[d];
    end
  endtask

  task automatic change(input logic [41:0] segs,
                        input logic [5:0] dps);
    for (int d = 0; d < 6; d++) begin
      tbl_seg[0][d] = tbl_seg[1][d];
      tbl_dp[0][d]  = tbl_dp[1][d];
    end
    load_tbl(1, segs, dps);
    new_from = (k + FRAME) / FRAME;
  endtask

  task automatic step();
    exp_t e;
    sb.push_back(model(k + 1));
    @(negedge clk);
    e = sb.pop_front();
    n_assert++;
    assert (an_n === e.an) else begin
      n_fail++;
      $error("FAIL %s k=%0d an_n got %h exp %h", tag, k, an_n, e.an);
    end
    if (e.active) begin
      n_assert++;
      assert (seg_n === e.seg) else begin
        n_fail++;
        $error("FAIL %s k=%0d seg_n got %h exp %h", tag, k, seg_n, e.seg);
      end
      n_assert++;
      assert (dp_n === e.dp) else begin
        n_fail++;
        $error("FAIL %s k=%0d dp_n got %b exp %b", tag, k, dp_n, e.dp);
      end
    end
  endtask

  task automatic run_until(input int target);
    while (k < target) step();
  endtask

  task automatic seek(input int dig);
    for (int i = 0; i < FRAME; i++) begin
      if (k >= 1 && ((k - 1) / SCAN) % 6 == dig
          && (k - 1) % SCAN == 2) break;
      step();
    end
  endtask

  task automatic chk_reset();
    n_assert++;
    assert (an_n === 6'h3F) else begin
      n_fail++;
      $error("FAIL %s an_n got %h exp 3f", tag, an_n);
    end
    n_assert++;
    assert (seg_n === 7'h7F) else begin
      n_fail++;
      $error("FAIL %s seg_n got %h exp 7f", tag, seg_n);
    end
    n_assert++;
    assert (dp_n === 1'b1) else begin
      n_fail++;
      $error("FAIL %s dp_n got %b exp 1", tag, dp_n);
    end
  endtask

  initial begin
    display_hour = 8'd13;
    display_min  = 8'd45;
    display_sec  = 8'd7;
    is_pm        = 1'b0;
    hour_format  = 1'b0;
    blink_sel    = 2'b00;
    load_tbl(0, {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78}, 6'b101011);
    load_tbl(1, {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78}, 6'b101011);
    new_from = 0;

    tag = "reset";
    repeat (2) @(negedge clk);
    chk_reset();
    reset = 1'b0;

    tag = "h24";
    repeat (2 * FRAME + 2) step();

    tag = "h12";
    display_hour = 8'd9;
    is_pm        = 1'b1;
    hour_format  = 1'b1;
    change({7'h7F, 7'h10, 7'h19, 7'h12, 7'h40, 7'h78}, 6'b101010);
    run_until(FRAME * (new_from + 2));

    tag = "sec59";
    display_sec = 8'd59;
    change({7'h7F, 7'h10, 7'h19, 7'h12, 7'h12, 7'h10}, 6'b101010);
    run_until(FRAME * (new_from + 2));

    tag = "tear_sec";
    seek(3);
    display_sec = 8'd0;
    change({7'h7F, 7'h10, 7'h19, 7'h12, 7'h40, 7'h40}, 6'b101010);
    run_until(FRAME * (new_from + 2));

    tag = "tear_min";
    seek(1);
    display_min = 8'd30;
    change({7'h7F, 7'h10, 7'h30, 7'h40, 7'h40, 7'h40}, 6'b101010);
    run_until(FRAME * (new_from + 2));

    tag = "blink_min";
    blink_sel = 2'b10;
    repeat (200) step();
    blink_sel = 2'b00;
    repeat (FRAME) step();

    tag = "overflow";
    display_hour = 8'd13;
    is_pm        = 1'b0;
    hour_format  = 1'b0;
    display_min  = 8'd120;
    display_sec  = 8'd0;
    change({7'h79, 7'h30, 7'h3F, 7'h3F, 7'h40, 7'h40}, 6'b101011);
    run_until(FRAME * (new_from + 2));

    tag = "mid_reset";
    seek(2);
    #2 reset = 1'b1;
    #1 chk_reset();
    repeat (2) @(negedge clk);
    chk_reset();
    load_tbl(0, {7'h79, 7'h30, 7'h3F, 7'h3F, 7'h40, 7'h40}, 6'b101011);
    load_tbl(1, {7'h79, 7'h30, 7'h3F, 7'h3F, 7'h40, 7'h40}, 6'b101011);
    new_from = 0;
    reset = 1'b0;

    tag = "after_reset";
    repeat (FRAME + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
